// File: rtl/noc_pkg.sv
// Shared NoC definitions for the packet injector: header layout, address type, FSM states.
// PACKET_INJECTOR_CHECKSUM_EN adds the CHECKSUM trailer state.
package noc_pkg;

   localparam int HDR_DEST_LSB = 0;
   localparam int HDR_SRC_LSB  = 4;
   localparam int HDR_LEN_LSB  = 8;
   localparam int HDR_W        = 16;

   typedef logic [3:0] net_addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_HEADER,
      ST_PAYLOAD
`ifdef PACKET_INJECTOR_CHECKSUM_EN
      , ST_CHECKSUM
`endif
   } inj_state_t;

   // Low 16 bits of the header; the caller zero-extends to the data width.
   function automatic logic [HDR_W-1:0] build_header(net_addr_t dest, net_addr_t src,
                                                     logic [7:0] len);
      logic [HDR_W-1:0] h;
      h = '0;
      h[HDR_DEST_LSB +: 4] = dest;
      h[HDR_SRC_LSB  +: 4] = src;
      h[HDR_LEN_LSB  +: 8] = len;
      return h;
   endfunction

endpackage

// File: rtl/packet_injector_if.sv
// PE-side Valid/Ready channel and router-side Req/Ack channel of the packet injector.
interface packet_injector_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NET_ADDR   = 4
);
   logic                  Tx_Valid;
   logic                  Tx_Ready;
   logic [DATA_WIDTH-1:0] Tx_Data;
   logic                  Tx_Last;
   logic [NET_ADDR-1:0]   Tx_Dest;
   logic                  M_Req;
   logic                  M_Ack;
   logic [DATA_WIDTH-1:0] M_Data;
   logic                  Busy;
   logic                  Pkt_Sent;

   modport slave (
      input  Tx_Valid, Tx_Data, Tx_Last, Tx_Dest, M_Ack,
      output Tx_Ready, M_Req, M_Data, Busy, Pkt_Sent
   );

   modport master (
      output Tx_Valid, Tx_Data, Tx_Last, Tx_Dest, M_Ack,
      input  Tx_Ready, M_Req, M_Data, Busy, Pkt_Sent
   );
endinterface

// File: rtl/inj_payload_store.sv
// Payload buffer for one packet: synchronous write, combinational read.
module inj_payload_store #(
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_PACKET_LEN = 8,
   parameter int AW             = 3
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem [MAX_PACKET_LEN];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/packet_injector.sv
// Store-and-forward NoC transmit stage: collect one packet from the PE, then send header + payload.
// Define PACKET_INJECTOR_CHECKSUM_EN to append an XOR trailer word after the payload.
module packet_injector
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_PACKET_LEN = 8,
   parameter int NET_ADDR       = 4,
   parameter int ADDRX          = 0,
   parameter int ADDRY          = 0
) (
   input  logic               Clock,
   input  logic               Reset,
   packet_injector_if.slave   bus
);
   localparam int CW = $clog2(MAX_PACKET_LEN + 1);
   localparam int AW = (MAX_PACKET_LEN > 1) ? $clog2(MAX_PACKET_LEN) : 1;
   localparam net_addr_t     SRC_ADDR = {2'(ADDRY), 2'(ADDRX)};
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PACKET_LEN);

   inj_state_t            state;
   logic [CW-1:0]         count, rd_ptr, count_nxt;
   net_addr_t             dest_q, hdr_dest;
   logic                  tx_ready_q, m_req_q, busy_q, pkt_sent_q;
   logic [DATA_WIDTH-1:0] m_data_q, rd_data, hdr_word;
   logic                  tx_fire, m_fire, pkt_end;
   logic [AW-1:0]         wr_idx, rd_idx;

   // tx_ready_q is only ever high in IDLE/COLLECT, so it also gates stray Tx_Valid.
   assign tx_fire   = bus.Tx_Valid & tx_ready_q;
   assign m_fire    = m_req_q & bus.M_Ack;
   assign count_nxt = (state == ST_IDLE) ? CW'(1) : count + CW'(1);
   assign pkt_end   = bus.Tx_Last | (count_nxt == MAX_CNT);
   assign hdr_dest  = (state == ST_IDLE) ? net_addr_t'(bus.Tx_Dest) : dest_q;
   assign hdr_word  = DATA_WIDTH'(build_header(hdr_dest, SRC_ADDR, 8'(count_nxt)));
   assign wr_idx    = (state == ST_IDLE) ? '0 : AW'(count);
   // Read port looks one word ahead so the registered M_Data is ready on each Ack.
   assign rd_idx    = (state == ST_PAYLOAD) ? AW'(rd_ptr + CW'(1)) : '0;

   inj_payload_store #(
      .DATA_WIDTH     (DATA_WIDTH),
      .MAX_PACKET_LEN (MAX_PACKET_LEN),
      .AW             (AW)
   ) u_store (
      .clk     (Clock),
      .wr_en   (tx_fire),
      .wr_idx  (wr_idx),
      .wr_data (bus.Tx_Data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

`ifdef PACKET_INJECTOR_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q;

   always_ff @(posedge Clock) begin
      if (tx_fire) csum_q <= (state == ST_IDLE) ? bus.Tx_Data : (csum_q ^ bus.Tx_Data);
   end
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= ST_IDLE;
         count      <= '0;
         rd_ptr     <= '0;
         dest_q     <= '0;
         tx_ready_q <= 1'b1;
         m_req_q    <= 1'b0;
         m_data_q   <= '0;
         busy_q     <= 1'b0;
         pkt_sent_q <= 1'b0;
      end else begin
         pkt_sent_q <= 1'b0;
         case (state)
            ST_IDLE, ST_COLLECT: begin
               if (tx_fire) begin
                  count  <= count_nxt;
                  busy_q <= 1'b1;
                  if (state == ST_IDLE) dest_q <= net_addr_t'(bus.Tx_Dest);
                  if (pkt_end) begin
                     state      <= ST_HEADER;
                     tx_ready_q <= 1'b0;
                     m_req_q    <= 1'b1;
                     m_data_q   <= hdr_word;
                  end else begin
                     state <= ST_COLLECT;
                  end
               end
            end
            ST_HEADER: begin
               if (m_fire) begin
                  state    <= ST_PAYLOAD;
                  rd_ptr   <= '0;
                  m_data_q <= rd_data;
               end
            end
            ST_PAYLOAD: begin
               if (m_fire) begin
                  if (rd_ptr == count - CW'(1)) begin
`ifdef PACKET_INJECTOR_CHECKSUM_EN
                     state    <= ST_CHECKSUM;
                     m_data_q <= csum_q;
`else
                     state      <= ST_IDLE;
                     count      <= '0;
                     tx_ready_q <= 1'b1;
                     m_req_q    <= 1'b0;
                     m_data_q   <= '0;
                     busy_q     <= 1'b0;
                     pkt_sent_q <= 1'b1;
`endif
                  end else begin
                     rd_ptr   <= rd_ptr + CW'(1);
                     m_data_q <= rd_data;
                  end
               end
            end
`ifdef PACKET_INJECTOR_CHECKSUM_EN
            ST_CHECKSUM: begin
               if (m_fire) begin
                  state      <= ST_IDLE;
                  count      <= '0;
                  tx_ready_q <= 1'b1;
                  m_req_q    <= 1'b0;
                  m_data_q   <= '0;
                  busy_q     <= 1'b0;
                  pkt_sent_q <= 1'b1;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.Tx_Ready = tx_ready_q;
   assign bus.M_Req    = m_req_q;
   assign bus.M_Data   = m_data_q;
   assign bus.Busy     = busy_q;
   assign bus.Pkt_Sent = pkt_sent_q;
endmodule

// File: tb/tb_packet_injector.sv
// Self-checking bench for packet_injector: table-driven packets, corner sequences, random traffic.
module tb_packet_injector;
   localparam int MAXL = 8;
`ifdef PACKET_INJECTOR_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam logic [3:0] SRC = 4'h9;  // node X=1, Y=2

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   ack_mode = 0;  // 0: ack high, 1: random, 2: ack low
   logic ack_rand = 1'b1;

   packet_injector_if #(.DATA_WIDTH(32), .NET_ADDR(4)) bus ();

   packet_injector #(
      .DATA_WIDTH(32), .MAX_PACKET_LEN(MAXL), .NET_ADDR(4), .ADDRX(1), .ADDRY(2)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) ack_rand = 1'($urandom % 2);
   assign bus.M_Ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? ack_rand : 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Reference model: packets are split on Last or at MAXL words
   typedef struct { logic [31:0] d; logic [3:0] dest; } pe_t;
   pe_t         cur[$];
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int          exp_pkts = 0;
   int          obs_pkts = 0;

   function automatic void model_push(logic [31:0] d, logic last, logic [3:0] dest);
      logic [31:0] x;
      pe_t w;
      w.d = d;
      w.dest = dest;
      cur.push_back(w);
      if (last || cur.size() == MAXL) begin
         exp_q.push_back({16'h0, 8'(cur.size()), SRC, cur[0].dest});
         x = 0;
         foreach (cur[i]) begin
            exp_q.push_back(cur[i].d);
            x = x ^ cur[i].d;
         end
         if (CK == 1) exp_q.push_back(x);
         exp_pkts++;
         cur.delete();
      end
   endfunction

   // Network-side monitor, sampled mid-cycle
   logic        stall_prev = 1'b0;
   logic [31:0] stall_data = '0;
   always @(negedge clk) begin
      #2;
      if (bus.M_Req && bus.M_Ack) obs_q.push_back(bus.M_Data);
      if (bus.Pkt_Sent) obs_pkts++;
      if (stall_prev && bus.M_Req) chk("hold_stable", bus.M_Data, stall_data);
      stall_prev = bus.M_Req && !bus.M_Ack;
      stall_data = bus.M_Data;
   end

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic pe_word(input logic [31:0] d, input logic last, input logic [3:0] dest);
      int n;
      n = 0;
      bus.Tx_Valid = 1'b1;
      bus.Tx_Data  = d;
      bus.Tx_Last  = last;
      bus.Tx_Dest  = dest;
      while (!bus.Tx_Ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) timeout_fail("tx_ready_wait");
      else begin
         @(posedge clk);
         model_push(d, last, dest);
      end
      @(negedge clk);
      bus.Tx_Valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((bus.Busy || exp_pkts != obs_pkts) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) timeout_fail(name);
      @(negedge clk);
   endtask

   task automatic compare_streams(input string name);
      chk({name, "_nwords"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s_w%0d", name, i), obs_q[i], exp_q[i]);
      chk({name, "_pkts"}, 32'(obs_pkts), 32'(exp_pkts));
      obs_q.delete();
      exp_q.delete();
      obs_pkts = 0;
      exp_pkts = 0;
   endtask

   typedef struct {
      logic [3:0]  dest;
      int          n;
      logic [31:0] base;
      logic [31:0] exp_hdr;
   } vec_t;
   vec_t tbl[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      int n, k;

      tbl[0] = '{dest: 4'h5, n: 1, base: 32'hA5A5_0001, exp_hdr: 32'h0000_0195};
      tbl[1] = '{dest: 4'h3, n: 3, base: 32'h0000_0001, exp_hdr: 32'h0000_0393};
      tbl[2] = '{dest: 4'hF, n: 8, base: 32'h0000_0010, exp_hdr: 32'h0000_089F};
      tbl[3] = '{dest: 4'h0, n: 5, base: 32'h0000_0003, exp_hdr: 32'h0000_0590};

      rst = 1'b1;
      bus.Tx_Valid = 1'b0;
      bus.Tx_Data  = '0;
      bus.Tx_Last  = 1'b0;
      bus.Tx_Dest  = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx_ready", 32'(bus.Tx_Ready), 32'd1);
      chk("rst_m_req",    32'(bus.M_Req),    32'd0);
      chk("rst_m_data",   bus.M_Data,        32'd0);
      chk("rst_busy",     32'(bus.Busy),     32'd0);
      chk("rst_pkt_sent", 32'(bus.Pkt_Sent), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven packets with M_Ack tied high
      ack_mode = 0;
      foreach (tbl[t]) begin
         for (int i = 0; i < tbl[t].n; i++)
            pe_word(tbl[t].base << i, i == tbl[t].n - 1, tbl[t].dest);
         chk($sformatf("t%0d_hdr_latency_req", t), 32'(bus.M_Req), 32'd1);
         chk($sformatf("t%0d_hdr", t), bus.M_Data, tbl[t].exp_hdr);
         chk($sformatf("t%0d_tx_ready_low", t), 32'(bus.Tx_Ready), 32'd0);
         n = 0;
         k = 0;
         while (bus.M_Req && k < 50) begin
            n++;
            k++;
            @(negedge clk);
         end
         chk($sformatf("t%0d_req_cycles", t), 32'(n), 32'(tbl[t].n + 1 + CK));
         wait_drain($sformatf("t%0d_drain", t));
         compare_streams($sformatf("t%0d", t));
      end

      // Header stalled for 4 cycles
      ack_mode = 2;
      pe_word(32'h11, 1'b0, 4'hA);
      pe_word(32'h22, 1'b0, 4'hA);
      pe_word(32'h33, 1'b1, 4'hA);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall_hdr_%0d", i), bus.M_Data, 32'h0000_039A);
         chk($sformatf("stall_req_%0d", i), 32'(bus.M_Req), 32'd1);
         @(negedge clk);
      end
      ack_mode = 0;
      wait_drain("stall_drain");
      compare_streams("stall");

      // Ten words, Last only on the tenth: truncation at MAXL
      ack_mode = 1;
      for (int i = 1; i <= 10; i++) pe_word(32'h100 + 32'(i), i == 10, 4'h6);
      wait_drain("trunc_drain");
      w = (obs_q.size() > 0) ? obs_q[0] : 32'hFFFF_FFFF;
      chk("trunc_len1", 32'(w[15:8]), 32'd8);
      w = (obs_q.size() > 9 + CK) ? obs_q[9 + CK] : 32'hFFFF_FFFF;
      chk("trunc_len2", 32'(w[15:8]), 32'd2);
      compare_streams("trunc");

      // Tx_Valid held high while the packet is being sent
      pe_word(32'hBEEF_0001, 1'b0, 4'h7);
      pe_word(32'hBEEF_0002, 1'b1, 4'h7);
      bus.Tx_Valid = 1'b1;
      bus.Tx_Data  = 32'hDEAD_DEAD;
      bus.Tx_Last  = 1'b1;
      k = 0;
      while (bus.Busy && k < 200) begin
         chk("busy_tx_ready", 32'(bus.Tx_Ready), 32'd0);
         @(negedge clk);
         k++;
      end
      bus.Tx_Valid = 1'b0;
      wait_drain("hold_drain");
      compare_streams("hold");

      // Reset during PAYLOAD after 2 of 5 payload words
      ack_mode = 2;
      for (int i = 0; i < 5; i++) pe_word(32'hC000 + 32'(i), i == 4, 4'h2);
      ack_mode = 0;
      repeat (3) @(negedge clk);
      chk("rst_mid_cur_word", bus.M_Data, 32'hC002);
      ack_mode = 2;
      rst = 1'b1;
      #1;
      chk("rst_mid_m_req",    32'(bus.M_Req),    32'd0);
      chk("rst_mid_tx_ready", 32'(bus.Tx_Ready), 32'd1);
      chk("rst_mid_busy",     32'(bus.Busy),     32'd0);
      @(negedge clk);
      rst = 1'b0;
      obs_q.delete();
      exp_q.delete();
      cur.delete();
      obs_pkts = 0;
      exp_pkts = 0;
      ack_mode = 0;
      @(negedge clk);
      pe_word(32'hE000_0001, 1'b0, 4'hC);
      pe_word(32'hE000_0002, 1'b1, 4'hC);
      chk("post_rst_hdr", bus.M_Data, 32'h0000_029C);
      wait_drain("post_rst_drain");
      compare_streams("post_rst");

`ifdef PACKET_INJECTOR_CHECKSUM_EN
      pe_word(32'h1, 1'b0, 4'h3);
      pe_word(32'h2, 1'b0, 4'h3);
      pe_word(32'h4, 1'b1, 4'h3);
      wait_drain("csum_drain");
      w = (obs_q.size() > 4) ? obs_q[4] : 32'hFFFF_FFFF;
      chk("csum_trailer", w, 32'h7);
      w = (obs_q.size() > 0) ? obs_q[0] : 32'hFFFF_FFFF;
      chk("csum_hdr_len", 32'(w[15:8]), 32'd3);
      compare_streams("csum");
`endif

      // Random traffic with random Ack and PE gaps
      ack_mode = 1;
      for (int i = 0; i < 80; i++) begin
         pe_word($urandom, (i == 79) || ($urandom_range(0, 4) == 0), 4'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain("rand_drain");
      compare_streams("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
